soc_noc_packet_arbiter: RTL
===========================

Name: soc_noc_packet_arbiter

Overview:
- Packet-atomic round-robin arbiter that lets NUM_PORTS on-tile NoC packet sources share one outgoing NoC channel.
- Sources are the MPSIMPLE message buffer, the DMA engine and the debug bridge.
- Sits in the compute tile between the network-adapter sources and one noc_out_* channel lane.
- Once a packet starts, the grant is held until its last flit is accepted, so flits of different packets never interleave.

Parameters:
- FLIT_WIDTH, 32, width of one flit.
- NUM_PORTS, 2, number of requesting sources (2..8).
- PORT_W, $clog2(NUM_PORTS) (localparam), width of the grant index.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_flit  in  NUM_PORTS*FLIT_WIDTH  packed per-port flits; port p occupies [p*FLIT_WIDTH +: FLIT_WIDTH].
- in_last  in  NUM_PORTS  per-port last-flit marker.
- in_valid  in  NUM_PORTS  per-port flit valid.
- in_ready  out  NUM_PORTS  per-port accept; at most one bit high per cycle.
- out_flit  out  FLIT_WIDTH  flit of the granted port.
- out_last  out  1  last marker of the granted port.
- out_valid  out  1  valid to NoC.
- out_ready  in  1  NoC accept.
- grant_idx  out  PORT_W  index of the currently owning or selected port.
- busy  out  1  high while a packet is locked (state LOCKED).

Behaviour:
- Handshake: a transfer occurs on any cycle with valid & ready. Sources must hold flit/last stable while valid & !ready.
- State IDLE:
  - sel = first port with in_valid set, searching from rr_ptr upward with wrap-around.
  - Forward in the same cycle (zero latency): out_valid = |in_valid, out_flit/out_last = port sel, in_ready[sel] = out_ready, grant_idx = sel.
  - IDLE -> LOCKED with owner <= sel when |in_valid and !(out_ready & in_last[sel]).
  - A single-flit packet accepted in IDLE stays in IDLE and sets rr_ptr <= sel+1 (mod NUM_PORTS).
  - No request: out_valid = 0, in_ready = 0, grant_idx holds its last value.
- State LOCKED:
  - Only owner is forwarded: out_valid = in_valid[owner], in_ready[owner] = out_ready, all other in_ready = 0.
  - A new request from a higher-priority port never pre-empts the owner.
  - Owner dropping valid mid-packet: out_valid = 0 (bubble); the lock is held indefinitely.
  - On out_valid & out_ready & in_last[owner]: LOCKED -> IDLE and rr_ptr <= owner+1 (mod NUM_PORTS).
  - The next packet can be granted on the cycle immediately after the last-flit handshake, so back-to-back packets have no dead cycle.
- Because the grant is locked whenever out_valid is asserted without completing the packet, out_flit is stable while out_valid & !out_ready.
- Fairness: any continuously requesting port is served within NUM_PORTS-1 packets.
- Reset (synchronous):
  - state = IDLE, rr_ptr = 0, owner = 0, grant_idx = 0.
  - out_valid = 0 and in_ready = 0 during reset.
  - Reset mid-packet abandons the lock; the partial packet is the sources' responsibility (they are reset by the same rst_sys).
- Widths:
  - rr_ptr increment wraps explicitly at NUM_PORTS; it must not rely on power-of-two overflow.
  - Simulation assertions: grant_idx < NUM_PORTS always; $onehot0(in_ready) always.
- out_flit in IDLE with no request: drive flit of port sel (don't-care to consumers); not X-generating.

Decomposition:
- Package soc_noc_arb_pkg:
  - localparam for maximum NUM_PORTS (8).
  - Typedef arb_state_t {IDLE, LOCKED}.
  - Function rr_next(ptr, n) implementing the wrap-around increment.
- Sub-module soc_rr_select #(NUM_PORTS): purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: sel index and any_req.
  - Implemented as a doubled-vector priority scan.
- The top block holds the FSM, owner/rr_ptr registers and the flit mux.

Test Plan:
1. Reset, then only port 0 sends 3 flits (A0,A1,A2 last) with out_ready=1 -> out_flit A0,A1,A2 on 3 consecutive cycles; busy=1 on cycles 1-2; IDLE and rr_ptr=1 after.
2. NUM_PORTS=2, both request simultaneously with 2-flit packets, rr_ptr=0 -> port0 packet completes first, then port1 with no gap; grant_idx sequence 0,0,1,1; in_ready[1]=0 during port0 packet.
3. Port1 owns a 4-flit packet; port0 asserts valid at flit 2 -> no pre-emption; port0 is granted on the cycle after port1's last flit.
4. out_ready=0 for 5 cycles with port0 flit 0x0000_BEEF valid, then port1 raises valid -> out_flit stays 0x0000_BEEF, grant_idx=0 stable, busy=1; transfer completes when out_ready=1.
5. Single-flit packets continuously from all 4 ports (NUM_PORTS=4), out_ready=1 -> grants 0,1,2,3,0,... one per cycle, busy never asserted.
6. Assert rst during flit 2 of a 4-flit packet -> next cycle out_valid=0, in_ready=0, state IDLE, rr_ptr=0; a new request after reset is granted to the lowest requesting port from 0.

Source files
------------

// File: rtl/soc_noc_arb_pkg.sv
// Shared types and helpers for the NoC packet arbiter: state encoding,
// port-count limit and the round-robin pointer increment.
package soc_noc_arb_pkg;

  localparam int MAX_PORTS = 8;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE   = 1'b0;
  localparam arb_state_t LOCKED = 1'b1;

  // Wraps at n explicitly so non-power-of-two port counts rotate correctly.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/soc_rr_select.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping around, found by scanning a doubled copy of the request vector.
module soc_rr_select
  import soc_noc_arb_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    rr_ptr,
  output logic [PORT_W-1:0]    sel,
  output logic                 any_req
);

  localparam int DW = $clog2(2 * NUM_PORTS);

  logic [2*NUM_PORTS-1:0] dbl;
  logic [DW-1:0]          idx;
  logic                   found;

  always_comb begin
    dbl   = {req, req};
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = DW'(rr_ptr) + DW'(i);
      if (!found && dbl[idx]) begin
        found = 1'b1;
        sel   = (idx >= DW'(NUM_PORTS)) ? PORT_W'(idx - DW'(NUM_PORTS)) : PORT_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/soc_noc_packet_arbiter.sv
// Packet-atomic round-robin arbiter: NUM_PORTS tile-local packet sources share
// one outgoing NoC lane; a started packet keeps the grant until its last flit.
module soc_noc_packet_arbiter
  import soc_noc_arb_pkg::*;
#(
  parameter  int FLIT_WIDTH = 32,
  parameter  int NUM_PORTS  = 2,
  localparam int PORT_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [NUM_PORTS-1:0]            in_last,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]           out_flit,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PORT_W-1:0]               grant_idx,
  output logic                            busy
);

  if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("soc_noc_packet_arbiter: NUM_PORTS out of range");
  end

  arb_state_t          state;
  logic [PORT_W-1:0]   owner;
  logic [PORT_W-1:0]   rr_ptr;
  logic [PORT_W-1:0]   grant_q;
  logic [PORT_W-1:0]   sel;
  logic [PORT_W-1:0]   cur;
  logic                any_req;

  soc_rr_select #(.NUM_PORTS(NUM_PORTS)) u_select (
    .req     (in_valid),
    .rr_ptr  (rr_ptr),
    .sel     (sel),
    .any_req (any_req)
  );

  // Handshake: a flit moves on every cycle where valid and ready are both high;
  // a source holds flit/last stable while valid is high and ready is low.
  always_comb begin
    cur       = (state == LOCKED) ? owner : sel;
    out_flit  = '0;
    out_last  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (cur == PORT_W'(p)) begin
        out_flit = in_flit[p*FLIT_WIDTH +: FLIT_WIDTH];
        out_last = in_last[p];
      end
    end
    in_ready  = '0;
    out_valid = 1'b0;
    grant_idx = grant_q;
    if (rst) begin
      grant_idx = '0;
    end else if (state == LOCKED) begin
      out_valid       = in_valid[owner];
      in_ready[owner] = out_ready;
      grant_idx       = owner;
    end else if (any_req) begin
      out_valid     = 1'b1;
      in_ready[sel] = out_ready;
      grant_idx     = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      grant_q <= '0;
    end else begin
      grant_q <= grant_idx;
      case (state)
        IDLE: begin
          if (any_req) begin
            // A single-flit packet accepted here never needs the lock.
            if (out_ready && in_last[sel]) begin
              rr_ptr <= PORT_W'(rr_next(int'(sel), NUM_PORTS));
            end else begin
              state <= LOCKED;
              owner <= sel;
            end
          end
        end
        default: begin
          if (in_valid[owner] && out_ready && in_last[owner]) begin
            state  <= IDLE;
            rr_ptr <= PORT_W'(rr_next(int'(owner), NUM_PORTS));
          end
        end
      endcase
    end
  end

  assign busy = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(grant_idx) < NUM_PORTS);
      assert ($onehot0(in_ready));
    end
  end

endmodule
